// File: rtl/mult_request_master.sv
// Sequencing master for the four-operand multiplier handshake: accepts an operand set,
// launches the multiplier, waits for done under a timeout guard, acknowledges, then responds.
module mult_request_master #(
    parameter int unsigned SIZE     = 32,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iReq_Valid,
    output logic                oReq_Ready,
    input  logic [SIZE-1:0]     iReq_A,
    input  logic [SIZE-1:0]     iReq_B,
    input  logic [SIZE-1:0]     iReq_C,
    input  logic [SIZE-1:0]     iReq_D,
    output logic [SIZE-1:0]     oData_A,
    output logic [SIZE-1:0]     oData_B,
    output logic [SIZE-1:0]     oData_C,
    output logic [SIZE-1:0]     oData_D,
    output logic                oValid_Data,
    output logic                oAcknoledged,
    input  logic                iDone,
    input  logic                iIdle,
    input  logic [4*SIZE-1:0]   iResult,
    output logic                oRsp_Valid,
    input  logic                iRsp_Ready,
    output logic [4*SIZE-1:0]   oRsp_Result,
    output logic                oRsp_Timeout,
    output logic [15:0]         oTxn_Count
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ACK,
        RESP
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic [TO_WIDTH-1:0] to_count;
    logic                accept;
    logic                to_hit;

    assign oReq_Ready = (state == IDLE) && iIdle;
    assign accept     = iReq_Valid && oReq_Ready;
    assign to_hit     = (to_count == TO_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (iDone || to_hit) state_next = ACK;
            ACK:     if (iIdle && !iDone) state_next = RESP;
            RESP:    if (iRsp_Ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they align with the state they decode.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oData_A      <= '0;
            oData_B      <= '0;
            oData_C      <= '0;
            oData_D      <= '0;
            oValid_Data  <= 1'b0;
            oAcknoledged <= 1'b0;
            oRsp_Valid   <= 1'b0;
            oRsp_Result  <= '0;
            oRsp_Timeout <= 1'b0;
            oTxn_Count   <= '0;
            to_count     <= '0;
        end else begin
            oValid_Data  <= (state_next == LAUNCH);
            oAcknoledged <= (state_next == ACK);
            oRsp_Valid   <= (state_next == RESP);

            if (state == IDLE && accept) begin
                oData_A <= iReq_A;
                oData_B <= iReq_B;
                oData_C <= iReq_C;
                oData_D <= iReq_D;
            end

            if (state == LAUNCH) begin
                to_count <= '0;
            end

            if (state == WAIT) begin
                if (iDone) begin
                    oRsp_Result  <= iResult;
                    oRsp_Timeout <= 1'b0;
                end else if (to_hit) begin
                    oRsp_Result  <= '0;
                    oRsp_Timeout <= 1'b1;
                end else begin
                    to_count <= to_count + 1'b1;
                end
            end

            if (state == RESP && iRsp_Ready) begin
                oTxn_Count <= oTxn_Count + 16'd1;
            end
        end
    end

endmodule

// File: doc/mult_request_master.md
# mult_request_master

Sequencing master for the four-operand multiplier handshake (iValid_Data / oDone / iAcknoledged / oIdle). It accepts an operand set from an upstream valid/ready port, launches the multiplier, and waits for done with a timeout guard. It then captures the 4*SIZE result, acknowledges the multiplier back to idle, and returns the result on a downstream valid/ready port. It sits between the host datapath and the multiplier instance, which shares its Clock and Reset.

## Interface
- SIZE, 32, operand width; result width is 4*SIZE
- TIMEOUT, 255, maximum WAIT cycles before the transaction is abandoned (1..2^TO_WIDTH-1)
- TO_WIDTH, 8, timeout counter width
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- iReq_Valid  in  1  upstream operand set valid
- oReq_Ready  out  1  master can accept an operand set
- iReq_A, iReq_B, iReq_C, iReq_D  in  SIZE each  operands
- oData_A, oData_B, oData_C, oData_D  out  SIZE each  registered operands to multiplier
- oValid_Data  out  1  launch pulse to multiplier
- oAcknoledged  out  1  acknowledge to multiplier
- iDone  in  1  multiplier result ready
- iIdle  in  1  multiplier idle
- iResult  in  4*SIZE  multiplier result
- oRsp_Valid  out  1  response valid
- iRsp_Ready  in  1  downstream accepts response
- oRsp_Result  out  4*SIZE  captured product (0 on timeout)
- oRsp_Timeout  out  1  response is a timeout, not a product
- oTxn_Count  out  16  completed responses, wraps 0xFFFF -> 0

## Operation
- States: IDLE, LAUNCH, WAIT, ACK, RESP; reset state IDLE.
- oReq_Ready = (state==IDLE) & iIdle, combinational. It is the only non-registered output.
- IDLE:
  - On iReq_Valid & oReq_Ready: latch iReq_A..D into oData_A..D, go to LAUNCH.
  - Otherwise hold; operand registers are unchanged.
- LAUNCH:
  - oValid_Data=1 for exactly this one cycle.
  - Clear timeout counter, go to WAIT.
- WAIT:
  - If iDone=1: capture iResult into oRsp_Result, set timeout flag=0, go to ACK.
  - Else if counter==TIMEOUT-1: set oRsp_Result=0, timeout flag=1, go to ACK.
  - Else counter+1.
  - iDone has priority over timeout in the same cycle.
- ACK:
  - oAcknoledged=1 while in ACK.
  - Leave for RESP on the first cycle iIdle=1 with iDone=0.
  - No timeout in ACK.
- RESP:
  - oRsp_Valid=1; oRsp_Result and oRsp_Timeout are held stable.
  - On iRsp_Ready: oTxn_Count+1 (mod 2^16), go to IDLE.
- iReq_Valid is ignored outside IDLE. iDone and iResult are ignored outside WAIT.
- oData_A..D hold their values until the next accepted request.
- Reset mid-operation (any state): all registers return to reset values. The transaction is lost and no response is issued.

## Timing
- Reset values: oData_A..D=0, oValid_Data=0, oAcknoledged=0, oRsp_Valid=0, oRsp_Result=0, oRsp_Timeout=0, oTxn_Count=0. oReq_Ready follows iIdle.
- All registered outputs are decoded from registered state and update on the rising edge after the transition.
- Accept edge -> oValid_Data high the next cycle (LAUNCH), one cycle wide.
- iDone sampled high in WAIT at edge N -> oAcknoledged high from N+1.
- iIdle=1 & iDone=0 sampled in ACK -> oRsp_Valid high the next cycle.
- Timeout: with iDone never asserted, ACK is entered TIMEOUT cycles after WAIT is entered.
- Minimum turnaround from response handshake to next accept is 1 cycle: IDLE is entered, then accepts when iIdle=1.
- Back-to-back traffic: at most one transaction in flight.

## Test plan
- Product path: A=3, B=5, C=7, D=11, iRsp_Ready=1, multiplier model done after 100 cycles -> exactly one oValid_Data pulse; oAcknoledged until iIdle; oRsp_Result=1155, oRsp_Timeout=0, oTxn_Count=1.
- Full-scale operands: A=B=C=D=0xFFFFFFFF -> oRsp_Result=(2^32-1)^4 in 128 bits, exact.
- Timeout: model never asserts iDone -> ACK entered 255 cycles after WAIT; oRsp_Result=0, oRsp_Timeout=1; count increments.
- Backpressure: iRsp_Ready=0 for 10 cycles in RESP -> oRsp_Valid and oRsp_Result stable; oReq_Ready=0; iReq_Valid pulses ignored; response completes when iRsp_Ready rises.
- Reset asserted mid-WAIT (cycle 40) -> all outputs return to reset values asynchronously; no response; the next request completes normally.
- Counter wrap: preload via 65536 fast transactions with a 1-cycle model -> oTxn_Count returns to 0.
